// File: rtl/pps_timestamp_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pps_ts_pkg
//  Description : Shared types and helpers for the multi-channel PPS
//                timestamper: discipline-FSM state encoding, timestamp
//                record layout for the default build, and drift saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
package pps_ts_pkg;

    // Discipline state machine encoding (also driven out on the state port)
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } state_t;

    // Field widths of the default configuration (N_CH=4, SEC_WIDTH=6,
    // CNT_WIDTH=26, DRIFT_WIDTH=13)
    localparam int c_def_chan_w  = 2;
    localparam int c_def_sec_w   = 6;
    localparam int c_def_cnt_w   = 26;
    localparam int c_def_drift_w = 13;

    // Timestamp record as presented to the consumer, default widths
    typedef struct packed {
        logic [c_def_chan_w-1:0]         chan;
        logic [c_def_sec_w-1:0]          sec;
        logic [c_def_cnt_w-1:0]          cnt;
        logic signed [c_def_drift_w-1:0] drift;
        logic                            holdover;
    } ts_rec_t;

    localparam int c_ts_rec_w = $bits(ts_rec_t);

    // Clamp a signed value into the signed range of a w-bit field.
    // The result is returned at 32 bits; callers keep the low w bits.
    function automatic logic signed [31:0] sat_drift(input logic signed [31:0] v,
                                                     input int                 w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pps_timestamp_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : pps_timestamp_mc_if
//  Description : Valid/ready timestamp stream between the timestamper and
//                the downstream packet/DMA logic.
//                master : ts_valid, ts_chan, ts_sec, ts_cnt, ts_drift,
//                         ts_holdover out; ts_ready in
//                slave  : mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface pps_timestamp_mc_if
    import pps_ts_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SEC_WIDTH   = 6,
    parameter int CNT_WIDTH   = 26,
    parameter int DRIFT_WIDTH = 13
);
    localparam int c_chan_w = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                   ts_valid;
    logic                   ts_ready;
    logic [c_chan_w-1:0]    ts_chan;
    logic [SEC_WIDTH-1:0]   ts_sec;
    logic [CNT_WIDTH-1:0]   ts_cnt;
    logic [DRIFT_WIDTH-1:0] ts_drift;
    logic                   ts_holdover;

    modport master (
        output ts_valid, ts_chan, ts_sec, ts_cnt, ts_drift, ts_holdover,
        input  ts_ready
    );

    modport slave (
        input  ts_valid, ts_chan, ts_sec, ts_cnt, ts_drift, ts_holdover,
        output ts_ready
    );

endinterface
`default_nettype wire

// File: rtl/pps_timestamp_mc_ts_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ts_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. rd_data always
//                shows the head entry while empty is low. A write is taken
//                when full only if a read retires the head in the same cycle.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                wr_en, wr_data      write request and data
//                rd_en, rd_data      read (pop) request and head data
//                full, empty         occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_sync_fifo
    import pps_ts_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == (c_aw + 1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_rd    = rd_en & ~empty;
    assign w_wr    = wr_en & (~full | w_rd);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pps_timestamp_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pps_timestamp_mc
//  Description : GPS-disciplined multi-channel event timestamper. A cycle
//                counter is zeroed on each synchronised PPS rising edge and
//                the measured period error is kept as a saturated drift.
//                When PPS goes missing, PPS is fabricated from the last drift
//                (HOLDOVER) for up to MAX_HOLDOVER seconds before falling
//                back to IDLE. Rising edges on event_in are snapshotted per
//                channel and queued through a FWFT FIFO.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                pps             raw asynchronous GPS PPS
//                utc_load        strobe qualifying gps_utc_sec
//                gps_utc_sec     UTC second starting at the next PPS
//                event_in        per-channel event levels (clk domain)
//                ts              timestamp stream (master modport)
//                state           0 IDLE, 1 LOCKED, 2 HOLDOVER
//                ovf, clr_ovf    sticky per-channel drop flags and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module pps_timestamp_mc
    import pps_ts_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int SEC_WIDTH      = 6,
    parameter int SEC_MODULO     = 60,
    parameter int CNT_WIDTH      = 26,
    parameter int DRIFT_WIDTH    = 13,
    parameter int NOMINAL_CYCLES = 61_440_000,
    parameter int MARGIN         = 5,
    parameter int MAX_HOLDOVER   = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 pps,
    input  wire logic                 utc_load,
    input  wire logic [SEC_WIDTH-1:0] gps_utc_sec,
    input  wire logic [N_CH-1:0]      event_in,
    pps_timestamp_mc_if.master        ts,
    output logic      [1:0]           state,
    output logic      [N_CH-1:0]      ovf,
    input  wire logic                 clr_ovf
);
    localparam int c_chan_w = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_aw     = CNT_WIDTH + 1;
    localparam int c_hw     = $clog2(MAX_HOLDOVER + 1);

    typedef struct packed {
        logic [SEC_WIDTH-1:0]   sec;
        logic [CNT_WIDTH-1:0]   cnt;
        logic [DRIFT_WIDTH-1:0] drift;
        logic                   holdover;
    } snap_t;

    typedef struct packed {
        logic [c_chan_w-1:0] chan;
        snap_t               snap;
    } rec_t;

    localparam int c_rec_w = $bits(rec_t);

    // ------------------------------------------------------------------
    // PPS synchroniser and edge detect
    // ------------------------------------------------------------------
    logic r_pps_s1;
    logic r_pps_s2;
    logic r_pps_d;
    logic w_pps_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pps_s1 <= 1'b0;
            r_pps_s2 <= 1'b0;
            r_pps_d  <= 1'b0;
        end else begin
            r_pps_s1 <= pps;
            r_pps_s2 <= r_pps_s1;
            r_pps_d  <= r_pps_s2;
        end
    end

    assign w_pps_rise = r_pps_s2 & ~r_pps_d;

    // ------------------------------------------------------------------
    // Discipline datapath values used by the FSM
    // ------------------------------------------------------------------
    state_t                         r_state;
    state_t                         w_state_nxt;
    logic        [CNT_WIDTH-1:0]    r_counter;
    logic signed [DRIFT_WIDTH-1:0]  r_drift;
    logic        [c_hw-1:0]         r_hold_cnt;
    logic signed [c_aw-1:0]         w_cnt_s;
    logic signed [c_aw-1:0]         w_diff;
    logic signed [c_aw-1:0]         w_thresh;
    logic signed [31:0]             w_drift_sat;
    logic                           w_over;
    logic                           w_hold_last;
    logic                           w_fab;
    logic                           w_drift_ld;
    logic                           w_cnt_run;
    logic                           w_pps_event;

    assign w_cnt_s     = signed'({1'b0, r_counter});
    // Period just measured: the counter is one short of the cycle count
    // because it restarts at zero on the rise cycle itself.
    assign w_diff      = w_cnt_s + c_aw'(1) - c_aw'(NOMINAL_CYCLES);
    assign w_thresh    = c_aw'(NOMINAL_CYCLES) + c_aw'(r_drift) + c_aw'(MARGIN);
    assign w_over      = (w_cnt_s >= w_thresh);
    assign w_drift_sat = sat_drift(32'(w_diff), DRIFT_WIDTH);
    assign w_hold_last = (r_hold_cnt >= c_hw'(MAX_HOLDOVER - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state. A real PPS always wins over fabrication.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pps_rise)
                    w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!w_pps_rise && w_over)
                    w_state_nxt = (MAX_HOLDOVER <= 1) ? ST_IDLE : ST_HOLDOVER;
            end
            ST_HOLDOVER: begin
                if (w_pps_rise)
                    w_state_nxt = ST_LOCKED;
                else if (w_over && w_hold_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_fab      = 1'b0;
        w_drift_ld = 1'b0;
        w_cnt_run  = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                w_cnt_run  = 1'b1;
                w_fab      = ~w_pps_rise & w_over;
                w_drift_ld = w_pps_rise;
            end
            ST_HOLDOVER: begin
                w_cnt_run = 1'b1;
                w_fab     = ~w_pps_rise & w_over;
            end
            default: ;
        endcase
    end

    assign w_pps_event = w_pps_rise | w_fab;

    // Counter, drift and holdover count. A fabricated PPS lands MARGIN
    // cycles late, so the counter restarts at MARGIN to stay on phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter  <= '0;
            r_drift    <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_pps_rise)
                r_counter <= '0;
            else if (w_fab)
                r_counter <= CNT_WIDTH'(MARGIN);
            else if (w_cnt_run)
                r_counter <= r_counter + 1'b1;

            if (w_drift_ld)
                r_drift <= w_drift_sat[DRIFT_WIDTH-1:0];

            if (w_pps_rise)
                r_hold_cnt <= '0;
            else if (w_fab)
                r_hold_cnt <= (r_state == ST_LOCKED) ? c_hw'(1) : r_hold_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // UTC seconds. A load coincident with a PPS event is held for the
    // following event.
    // ------------------------------------------------------------------
    logic [SEC_WIDTH-1:0] r_sec;
    logic [SEC_WIDTH-1:0] r_pending_sec;
    logic                 r_pending_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec         <= '0;
            r_pending_sec <= '0;
            r_pending_v   <= 1'b0;
        end else begin
            if (w_pps_event) begin
                if (r_pending_v)
                    r_sec <= r_pending_sec;
                else
                    r_sec <= (r_sec == SEC_WIDTH'(SEC_MODULO - 1)) ? '0 : r_sec + 1'b1;
            end
            if (utc_load) begin
                r_pending_sec <= gps_utc_sec;
                r_pending_v   <= 1'b1;
            end else if (w_pps_event) begin
                r_pending_v   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event capture: one pending snapshot slot per channel
    // ------------------------------------------------------------------
    logic [N_CH-1:0]     r_event_d;
    logic [N_CH-1:0]     w_rise;
    logic [N_CH-1:0]     w_drop;
    logic [N_CH-1:0]     r_pend_v;
    snap_t               r_pend [N_CH];
    logic [N_CH-1:0]     r_ovf;
    snap_t               w_snap;
    logic [N_CH-1:0]     w_grant;
    logic [N_CH-1:0]     w_clr;
    logic                w_sel_v;
    logic [c_chan_w-1:0] w_sel;
    snap_t               w_sel_snap;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    rec_t                w_push_rec;
    rec_t                w_head;

    assign w_rise = event_in & ~r_event_d;
    assign w_drop = w_rise & r_pend_v;

    assign w_snap.sec      = r_sec;
    assign w_snap.cnt      = r_counter;
    assign w_snap.drift    = r_drift;
    assign w_snap.holdover = (r_state == ST_HOLDOVER);

    // Fixed priority: lowest-index pending channel (loop runs high to low
    // so the last hit is the lowest index).
    always_comb begin
        w_sel_v    = 1'b0;
        w_sel      = '0;
        w_sel_snap = '0;
        w_grant    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pend_v[i]) begin
                w_sel_v    = 1'b1;
                w_sel      = c_chan_w'(i);
                w_sel_snap = r_pend[i];
                w_grant    = N_CH'(1) << i;
            end
        end
    end

    // A full FIFO still accepts when its head is popped the same cycle
    assign w_pop      = ~w_empty & ts.ts_ready;
    assign w_push     = w_sel_v & (~w_full | w_pop);
    assign w_clr      = w_grant & {N_CH{w_push}};
    assign w_push_rec = {w_sel, w_sel_snap};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_event_d <= '0;
            r_pend_v  <= '0;
            r_ovf     <= '0;
            for (int i = 0; i < N_CH; i++)
                r_pend[i] <= '0;
        end else begin
            r_event_d <= event_in;
            r_ovf     <= (clr_ovf ? '0 : r_ovf) | w_drop;
            for (int i = 0; i < N_CH; i++) begin
                if (w_clr[i])
                    r_pend_v[i] <= 1'b0;
                // A slot can only be granted while already valid, so this
                // never collides with the clear above.
                if (w_rise[i] && !r_pend_v[i]) begin
                    r_pend_v[i] <= 1'b1;
                    r_pend[i]   <= w_snap;
                end
            end
        end
    end

    ts_sync_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_push_rec),
        .rd_en   (ts.ts_ready),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign ts.ts_valid    = ~w_empty;
    assign ts.ts_chan     = w_head.chan;
    assign ts.ts_sec      = w_head.snap.sec;
    assign ts.ts_cnt      = w_head.snap.cnt;
    assign ts.ts_drift    = w_head.snap.drift;
    assign ts.ts_holdover = w_head.snap.holdover;

    assign state = r_state;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pps_timestamp_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pps_timestamp_mc
//  Description : Directed self-checking bench for pps_timestamp_mc in a
//                reduced configuration (1000 cycles per second). Expected
//                stamps are queued when events are driven and compared as
//                the DUT hands them out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_timestamp_mc;
    import pps_ts_pkg::*;

    localparam int N_CH        = 4;
    localparam int SEC_WIDTH   = 6;
    localparam int CNT_WIDTH   = 26;
    localparam int DRIFT_WIDTH = 13;
    localparam int NOMINAL     = 1000;
    localparam int MARGIN      = 5;
    localparam int FAB_PERIOD  = 1004;   // counter walks MARGIN..NOMINAL+3+MARGIN

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pps;
    logic                 utc_load;
    logic [SEC_WIDTH-1:0] gps_utc_sec;
    logic [N_CH-1:0]      event_in;
    logic [1:0]           state;
    logic [N_CH-1:0]      ovf;
    logic                 clr_ovf;

    pps_timestamp_mc_if #(
        .N_CH        (N_CH),
        .SEC_WIDTH   (SEC_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .DRIFT_WIDTH (DRIFT_WIDTH)
    ) ts_if ();

    pps_timestamp_mc #(
        .N_CH           (N_CH),
        .SEC_WIDTH      (SEC_WIDTH),
        .SEC_MODULO     (60),
        .CNT_WIDTH      (CNT_WIDTH),
        .DRIFT_WIDTH    (DRIFT_WIDTH),
        .NOMINAL_CYCLES (NOMINAL),
        .MARGIN         (MARGIN),
        .MAX_HOLDOVER   (8),
        .FIFO_DEPTH     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pps         (pps),
        .utc_load    (utc_load),
        .gps_utc_sec (gps_utc_sec),
        .event_in    (event_in),
        .ts          (ts_if.master),
        .state       (state),
        .ovf         (ovf),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    int      zero_at  = 0;   // cycle after whose edge the counter reads 0
    int      pps_at   = 0;   // cycle at which the last raw PPS edge was driven
    int      fab_at   = 0;
    ts_rec_t sb[$];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target)
            tick(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int ch, input int s, input int cnt, input int drift, input logic hold);
        ts_rec_t e;
        e.chan     = 2'(ch);
        e.sec      = 6'(s);
        e.cnt      = 26'(cnt);
        e.drift    = 13'(drift);
        e.holdover = hold;
        sb.push_back(e);
    endtask

    // Raw edge now; synchroniser puts counter=0 three edges later
    task automatic pps_pulse();
        pps     = 1'b1;
        pps_at  = cyc;
        zero_at = cyc + 3;
        tick(5);
        pps     = 1'b0;
    endtask

    task automatic fire(input logic [N_CH-1:0] mask, input int s, input int cnt,
                        input int drift, input logic hold, input bit expect_push);
        event_in = mask;
        if (expect_push)
            for (int i = 0; i < N_CH; i++)
                if (mask[i])
                    push_exp(i, s, cnt, drift, hold);
        tick(1);
        event_in = '0;
        tick(1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        check(tag, sb.size(), 0);
        check({tag, "_valid"}, ts_if.ts_valid, 0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        ts_rec_t obs;
        ts_rec_t exp;
        if (!rst && ts_if.ts_valid && ts_if.ts_ready) begin
            obs = {ts_if.ts_chan, ts_if.ts_sec, ts_if.ts_cnt, ts_if.ts_drift, ts_if.ts_holdover};
            checks++;
            assert (sb.size() != 0)
            else begin
                failures++;
                $error("FAIL stamp_unexpected observed chan=%0d sec=%0d cnt=%0d expected none",
                       obs.chan, obs.sec, obs.cnt);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                assert (obs === exp)
                else begin
                    failures++;
                    $error("FAIL stamp observed chan=%0d sec=%0d cnt=%0d drift=%0d hold=%0b expected chan=%0d sec=%0d cnt=%0d drift=%0d hold=%0b",
                           obs.chan, obs.sec, obs.cnt, obs.drift, obs.holdover,
                           exp.chan, exp.sec, exp.cnt, exp.drift, exp.holdover);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        pps             = 1'b0;
        utc_load        = 1'b0;
        gps_utc_sec     = '0;
        event_in        = '0;
        clr_ovf         = 1'b0;
        ts_if.ts_ready  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_state", state, 0);
        check("reset_valid", ts_if.ts_valid, 0);
        check("reset_ovf", ovf, 0);

        // Stamp while IDLE: everything frozen at zero
        fire(4'b0001, 0, 0, 0, 1'b0, 1'b1);

        // Load UTC 58 ahead of the first PPS
        gps_utc_sec = 6'd58;
        utc_load    = 1'b1;
        tick(1);
        utc_load    = 1'b0;
        tick(5);

        // PPS 1: IDLE -> LOCKED, sec=58
        pps_pulse();
        tick_to(zero_at + 1);
        check("lock_state", state, 1);
        tick_to(zero_at + 100);
        fire(4'b0001, 58, cyc - zero_at, 0, 1'b0, 1'b1);

        // PPS 2, 1003 cycles later: drift=+3, sec=59
        tick_to(pps_at + 1003);
        pps_pulse();
        tick_to(zero_at + 50);
        check("locked_state", state, 1);
        event_in = 4'b1101;
        push_exp(0, 59, 50, 3, 1'b0);
        push_exp(2, 59, 50, 3, 1'b0);
        push_exp(3, 59, 50, 3, 1'b0);
        tick(1);
        event_in = '0;
        check("latency_t1", ts_if.ts_valid, 0);
        tick(1);
        check("latency_t2", ts_if.ts_valid, 1);

        // PPS 3: seconds wrap to 0
        tick_to(pps_at + 1003);
        pps_pulse();
        tick_to(zero_at + 10);
        fire(4'b0010, 0, 10, 3, 1'b0, 1'b1);

        // PPS stops: fabricate once the counter reaches 1008
        fab_at = zero_at + 1009;
        tick_to(fab_at - 1);
        check("pre_fab_state", state, 1);
        tick(1);
        check("holdover_state", state, 2);
        tick_to(fab_at + 20);
        fire(4'b0100, 1, 25, 3, 1'b1, 1'b1);

        // Eighth fabrication drops to IDLE
        tick_to(fab_at + 7 * FAB_PERIOD - 1);
        check("holdover_7", state, 2);
        tick(1);
        check("idle_after_8", state, 0);
        tick_to(fab_at + 7 * FAB_PERIOD + 10);
        fire(4'b1000, 8, MARGIN, 3, 1'b0, 1'b1);

        // Re-lock, lose PPS again, then a real PPS mid-holdover
        tick(20);
        pps_pulse();
        tick_to(zero_at + 1);
        check("relock_state", state, 1);
        fab_at = zero_at + 1009;
        tick_to(fab_at + 1);
        check("holdover2_state", state, 2);
        tick_to(fab_at + 200);
        pps_pulse();
        tick_to(zero_at + 1);
        check("holdover_relock", state, 1);
        tick_to(zero_at + 7);
        fire(4'b0001, 11, 7, 3, 1'b0, 1'b1);
        drain("drain_a");

        // Fill the FIFO with ready held low
        ts_if.ts_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            fire(4'b0001, 11, cyc - zero_at, 3, 1'b0, 1'b1);
        check("full_valid", ts_if.ts_valid, 1);
        fire(4'b0010, 11, cyc - zero_at, 3, 1'b0, 1'b1);
        check("ovf_before_drop", ovf, 0);
        fire(4'b0010, 0, 0, 0, 1'b0, 1'b0);
        check("ovf_drop", ovf, 4'b0010);
        check("full_sb_depth", sb.size(), 17);
        ts_if.ts_ready = 1'b1;
        drain("drain_full");
        check("ovf_sticky", ovf, 4'b0010);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_clear", ovf, 0);

        // Reset in the middle of holdover with the FIFO non-empty
        n = 0;
        while (state != 2'd2 && n < 2000) begin
            tick(1);
            n++;
        end
        check("reach_holdover", state, 2);
        ts_if.ts_ready = 1'b0;
        fire(4'b0100, 0, 0, 0, 1'b0, 1'b0);
        check("pre_rst_valid", ts_if.ts_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_valid", ts_if.ts_valid, 0);
        check("rst_ovf", ovf, 0);
        ts_if.ts_ready = 1'b1;
        fire(4'b0010, 0, 0, 0, 1'b0, 1'b1);
        drain("drain_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pps_timestamp_mc.md
Name: pps_timestamp_mc

Overview:
Multi-channel successor to the single-event PPS timestamper. It disciplines a cycle counter to the GPS PPS and tracks UTC seconds modulo a parameter. It runs a LOCKED/HOLDOVER state machine that fabricates PPS during dropouts, and stamps rising edges on N_CH event inputs. Stamps are queued in a FIFO with valid/ready output for the packet/DMA logic downstream of the preamble detectors.

Parameters:
N_CH, 4, number of event input channels (1..16)
SEC_WIDTH, 6, UTC seconds field width
SEC_MODULO, 60, seconds wrap value (≤ 2^SEC_WIDTH)
CNT_WIDTH, 26, cycle-counter width
DRIFT_WIDTH, 13, signed drift width
NOMINAL_CYCLES, 61_440_000, nominal clk cycles per second
MARGIN, 5, cycles past expected PPS before fabricating
MAX_HOLDOVER, 8, consecutive fabricated PPS before dropping to IDLE
FIFO_DEPTH, 16, timestamp FIFO entries (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pps  in  1  raw GPS PPS (asynchronous)
utc_load  in  1  one-cycle strobe: gps_utc_sec is valid
gps_utc_sec  in  SEC_WIDTH  UTC second beginning at the next PPS event
event_in  in  N_CH  per-channel event levels (clk-synchronous)
ts_valid  out  1  FIFO head valid
ts_ready  in  1  consumer accepts head
ts_chan  out  clog2(N_CH)  channel id of head
ts_sec  out  SEC_WIDTH  seconds at capture
ts_cnt  out  CNT_WIDTH  cycle counter at capture
ts_drift  out  DRIFT_WIDTH  signed drift at capture
ts_holdover  out  1  capture taken in HOLDOVER
state  out  2  0 IDLE, 1 LOCKED, 2 HOLDOVER
ovf  out  N_CH  sticky per-channel drop flags
clr_ovf  in  1  clears ovf (same-cycle new drop wins)

Behaviour:
- Reset (synchronous, active-high): all registers clear. state=IDLE, ts_valid=0, ovf=0, counter=0, sec=0, drift=0. The FIFO empties.
- PPS path: 2-flop synchronizer plus edge register. pps_rise is a 1-cycle strobe 3 cycles after the raw edge.
- States:
  - IDLE: counter and sec held. pps_rise → LOCKED, counter←0.
  - LOCKED: pps_rise → counter←0, drift←sat(counter+1−NOMINAL_CYCLES). counter ≥ NOMINAL_CYCLES+drift+MARGIN without pps_rise → fabricated PPS, counter←MARGIN, holdover_cnt←1, →HOLDOVER.
  - HOLDOVER: same fabrication rule with drift frozen, holdover_cnt++. pps_rise → LOCKED, counter←0, drift unchanged, holdover_cnt←0. holdover_cnt reaching MAX_HOLDOVER at a fabricated PPS → IDLE.
- pps_event = pps_rise or fabricated PPS. Fabricated and real in the same cycle are impossible because pps_rise has priority.
- Drift is saturated to the signed DRIFT_WIDTH range. Counter arithmetic is done at CNT_WIDTH+1 signed.
- Seconds:
  - utc_load latches gps_utc_sec into pending_sec and sets pending_v.
  - At a pps_event: if pending_v, sec←pending_sec and pending_v←0; otherwise sec←(sec==SEC_MODULO−1)?0:sec+1.
  - utc_load coincident with a pps_event applies at the following event.
- Events:
  - rise[i]=event_in[i]&~event_d[i].
  - On rise in cycle T, the snapshot {sec,counter,drift,state==HOLDOVER} is taken from cycle-T register values into pend[i], and pend_v[i] is set.
  - Rise while pend_v[i] already set → snapshot dropped, ovf[i]←1.
  - Rises in IDLE are still stamped (counter/sec frozen).
- Arbiter: each cycle FIFO not full → push lowest-index pend_v, clear it. The same cycle can accept a new rise on another channel.
  - Minimum latency: rise at T → push at T+1 → ts_valid at T+2.
  - FIFO full → pendings wait. No loss unless the same channel re-rises.
- Output: first-word-fall-through. Pop on ts_valid&ts_ready. Push and pop in the same cycle are allowed when full.

Decomposition:
- Package pps_ts_pkg:
  - state encoding (IDLE/LOCKED/HOLDOVER)
  - timestamp record typedef {chan, sec, cnt, drift, holdover}
  - record width constant
  - sat_drift function
- Sub-module ts_sync_fifo: parametrised width/depth FWFT FIFO with full/empty.

Test Plan:
- Reduced-size sim (NOMINAL_CYCLES=1000, MARGIN=5) with PPS every 1003 cycles → after second PPS drift=+3, state=LOCKED, counter resets 3 cycles after each raw edge.
- PPS stopped after lock with drift=+3 → fabricated PPS when counter reaches 1008, counter←5, state=HOLDOVER. After 8 fabrications → IDLE. Real PPS during holdover → LOCKED with drift still +3.
- utc_load with gps_utc_sec=58 → sec=58 at next PPS, then 59, then 0 (wrap at SEC_MODULO=60).
- Channels 0, 2 and 3 rise in the same cycle with ts_ready=1 → three FIFO entries in order ch0, ch2, ch3, all with identical sec/cnt/drift, first ts_valid 2 cycles after the rise.
- ts_ready=0 until FIFO holds 16 entries, then ch1 rises twice → first stamp pending, second sets ovf[1]. Release ready → 17 entries drain. clr_ovf clears ovf[1].
- Assert rst mid-holdover with FIFO non-empty → next cycle state=IDLE, ts_valid=0, ovf=0, drift=0, sec=0.
